// File: rtl/one_to_four_stream_demux_pkg.sv
// Shared definitions for the one-to-four stream demux: port indices, FIFO
// state encoding and default widths.
package one_to_four_stream_demux_pkg;

  localparam int DEFAULT_N     = 8;
  localparam int DEFAULT_CNT_W = 8;

  localparam logic [1:0] PORT0 = 2'b00;
  localparam logic [1:0] PORT1 = 2'b01;
  localparam logic [1:0] PORT2 = 2'b10;
  localparam logic [1:0] PORT3 = 2'b11;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } fifo_state_t;

  // One-hot decode of the {B,A} select.
  function automatic logic [3:0] port_onehot(input logic [1:0] sel);
    logic [3:0] hot;
    hot = 4'b0000;
    unique case (sel)
      PORT0:   hot = 4'b0001;
      PORT1:   hot = 4'b0010;
      PORT2:   hot = 4'b0100;
      default: hot = 4'b1000;
    endcase
    return hot;
  endfunction

endpackage

// File: rtl/one_to_four_stream_demux_if.sv
// Producer stream in, four consumer streams out. The master side drives the
// input word and the consumer ready bits; the slave side is the demux.
interface one_to_four_stream_demux_if
  import one_to_four_stream_demux_pkg::*;
#(
  parameter int N     = DEFAULT_N,
  parameter int CNT_W = DEFAULT_CNT_W
) ();

  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_data;
  logic             A;
  logic             B;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [N-1:0]     out_data0;
  logic [N-1:0]     out_data1;
  logic [N-1:0]     out_data2;
  logic [N-1:0]     out_data3;
  logic [CNT_W-1:0] out_count0;
  logic [CNT_W-1:0] out_count1;
  logic [CNT_W-1:0] out_count2;
  logic [CNT_W-1:0] out_count3;

  modport master (
    output in_valid, in_data, A, B, out_ready,
    input  in_ready, out_valid,
    input  out_data0, out_data1, out_data2, out_data3,
    input  out_count0, out_count1, out_count2, out_count3
  );

  modport slave (
    input  in_valid, in_data, A, B, out_ready,
    output in_ready, out_valid,
    output out_data0, out_data1, out_data2, out_data3,
    output out_count0, out_count1, out_count2, out_count3
  );

endinterface

// File: rtl/one_to_four_stream_demux_port_fifo.sv
// Two-entry FIFO for one consumer port, with head output, EMPTY/ONE/FULL
// state register and a wrapping count of delivered words.
module demux_port_fifo
  import one_to_four_stream_demux_pkg::*;
#(
  parameter int N     = DEFAULT_N,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [N-1:0]     data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic             full_o,
  output logic [N-1:0]     data_o,
  output logic [CNT_W-1:0] count_o
);

  fifo_state_t      state_q;
  logic [N-1:0]     head_q;
  logic [N-1:0]     tail_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             pop;

  assign valid_o = (state_q != EMPTY);
  assign full_o  = (state_q == FULL);
  assign data_o  = head_q;
  assign count_o = count_q;
  assign pop     = valid_o & ready_i;
  assign count_d = count_q + CNT_W'(pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      count_q <= count_d;
      unique case (state_q)
        EMPTY: begin
          if (push_i) begin
            head_q  <= data_i;
            state_q <= ONE;
          end
        end
        ONE: begin
          unique case ({push_i, pop})
            2'b10: begin
              tail_q  <= data_i;
              state_q <= FULL;
            end
            2'b01: state_q <= EMPTY;
            // Head leaves and the new word takes its place.
            2'b11: head_q <= data_i;
            default: ;
          endcase
        end
        FULL: begin
          // Without a pop the top level never pushes here.
          if (pop) begin
            head_q <= tail_q;
            if (push_i) begin
              tail_q <= data_i;
            end else begin
              state_q <= ONE;
            end
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/one_to_four_stream_demux.sv
// Routes each input word to one of four buffered consumer ports chosen by
// {B,A}; a stalled port only back-pressures words addressed to it.
module one_to_four_stream_demux
  import one_to_four_stream_demux_pkg::*;
#(
  parameter int N     = DEFAULT_N,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic                    clk,
  input  logic                    reset_n,
  one_to_four_stream_demux_if.slave bus
);

  logic [1:0]       sel;
  logic [3:0]       sel_hot;
  logic             accept;
  logic [3:0]       port_full;
  logic [3:0]       port_valid;
  logic [N-1:0]     port_data  [4];
  logic [CNT_W-1:0] port_count [4];

  assign sel     = {bus.B, bus.A};
  assign sel_hot = port_onehot(sel);

  // A full port can still take a word in the cycle its head is consumed.
  assign bus.in_ready = reset_n & (~port_full[sel] | bus.out_ready[sel]);
  assign accept       = bus.in_valid & bus.in_ready;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_port
      demux_port_fifo #(
        .N     (N),
        .CNT_W (CNT_W)
      ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (accept & sel_hot[gi]),
        .data_i  (bus.in_data),
        .ready_i (bus.out_ready[gi]),
        .valid_o (port_valid[gi]),
        .full_o  (port_full[gi]),
        .data_o  (port_data[gi]),
        .count_o (port_count[gi])
      );
    end
  endgenerate

  assign bus.out_valid  = port_valid;
  assign bus.out_data0  = port_data[0];
  assign bus.out_data1  = port_data[1];
  assign bus.out_data2  = port_data[2];
  assign bus.out_data3  = port_data[3];
  assign bus.out_count0 = port_count[0];
  assign bus.out_count1 = port_count[1];
  assign bus.out_count2 = port_count[2];
  assign bus.out_count3 = port_count[3];

endmodule

// File: tb/tb_one_to_four_stream_demux.sv
// Directed and randomised checks of the one-to-four stream demux.
module tb_one_to_four_stream_demux;

  logic clk = 1'b0;
  logic reset_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  one_to_four_stream_demux_if #(.N(8), .CNT_W(8)) bus ();

  one_to_four_stream_demux #(.N(8), .CNT_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic [1:0] s, input logic [3:0] r);
    bus.in_valid  = v;
    bus.in_data   = d;
    {bus.B, bus.A} = s;
    bus.out_ready = r;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    drive(1'b1, 8'hFF, 2'b00, 4'b1111);
    repeat (2) tick;
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 4'b0000) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0000", bus.out_valid); end
    n_cmp++; if ({bus.out_data0, bus.out_data1, bus.out_data2, bus.out_data3} !== 32'h0) begin
      n_bad++; $display("FAIL reset_out_data: got %h %h %h %h want all 00", bus.out_data0, bus.out_data1, bus.out_data2, bus.out_data3); end
    n_cmp++; if ({bus.out_count0, bus.out_count1, bus.out_count2, bus.out_count3} !== 32'h0) begin
      n_bad++; $display("FAIL reset_out_count: got %0d %0d %0d %0d want all 0", bus.out_count0, bus.out_count1, bus.out_count2, bus.out_count3); end
    drive(1'b0, 8'h00, 2'b00, 4'b0000);
    reset_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_basic;
    drive(1'b1, 8'hA1, 2'b10, 4'b0000);
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL basic_in_ready: got %b want 1", bus.in_ready); end
    tick;
    drive(1'b0, 8'h00, 2'b00, 4'b0000);
    n_cmp++; if (bus.out_valid !== 4'b0100) begin n_bad++; $display("FAIL basic_out_valid: got %b want 0100", bus.out_valid); end
    n_cmp++; if (bus.out_data2 !== 8'hA1) begin n_bad++; $display("FAIL basic_out_data2: got %h want a1", bus.out_data2); end
    n_cmp++; if (bus.out_count2 !== 8'd0) begin n_bad++; $display("FAIL basic_count_before: got %0d want 0", bus.out_count2); end
    bus.out_ready = 4'b0100;
    tick;
    bus.out_ready = 4'b0000;
    n_cmp++; if (bus.out_valid !== 4'b0000) begin n_bad++; $display("FAIL basic_after_pop_valid: got %b want 0000", bus.out_valid); end
    n_cmp++; if (bus.out_count2 !== 8'd1) begin n_bad++; $display("FAIL basic_out_count2: got %0d want 1", bus.out_count2); end
    $display("test_basic: word a1 -> port 2 delivered");
  endtask

  task automatic test_backpressure;
    drive(1'b1, 8'h11, 2'b01, 4'b0000);
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_w1: got %b want 1", bus.in_ready); end
    tick;
    bus.in_data = 8'h22;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_w2: got %b want 1", bus.in_ready); end
    tick;
    bus.in_data = 8'h33;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_w3_port1: got %b want 0", bus.in_ready); end
    tick;
    {bus.B, bus.A} = 2'b11;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_w3_port3: got %b want 1", bus.in_ready); end
    tick;
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.out_valid !== 4'b1010) begin n_bad++; $display("FAIL bp_out_valid: got %b want 1010", bus.out_valid); end
    n_cmp++; if (bus.out_data1 !== 8'h11 || bus.out_data3 !== 8'h33) begin
      n_bad++; $display("FAIL bp_heads: got p1=%h p3=%h want p1=11 p3=33", bus.out_data1, bus.out_data3); end
    bus.out_ready = 4'b1010;
    tick;
    n_cmp++; if (bus.out_valid !== 4'b0010 || bus.out_data1 !== 8'h22) begin
      n_bad++; $display("FAIL bp_second: got valid=%b p1=%h want valid=0010 p1=22", bus.out_valid, bus.out_data1); end
    tick;
    bus.out_ready = 4'b0000;
    n_cmp++; if (bus.out_valid !== 4'b0000 || bus.out_count1 !== 8'd2 || bus.out_count3 !== 8'd1) begin
      n_bad++; $display("FAIL bp_drain: got valid=%b c1=%0d c3=%0d want 0000 2 1", bus.out_valid, bus.out_count1, bus.out_count3); end
    $display("test_backpressure: 11,22 -> port 1, 33 -> port 3");
  endtask

  task automatic test_full_push_pop;
    drive(1'b1, 8'h44, 2'b00, 4'b0000);
    tick;
    bus.in_data = 8'h45;
    tick;
    bus.in_data   = 8'h55;
    bus.out_ready = 4'b0001;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL full_pp_ready: got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.out_data0 !== 8'h44) begin n_bad++; $display("FAIL full_pp_head0: got %h want 44", bus.out_data0); end
    tick;
    drive(1'b0, 8'h00, 2'b00, 4'b0000);
    #1;
    n_cmp++; if (bus.out_data0 !== 8'h45 || bus.out_valid[0] !== 1'b1) begin
      n_bad++; $display("FAIL full_pp_head1: got %h v=%b want 45 v=1", bus.out_data0, bus.out_valid[0]); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL full_pp_still_full: got in_ready %b want 0", bus.in_ready); end
    bus.out_ready = 4'b0001;
    tick;
    n_cmp++; if (bus.out_data0 !== 8'h55 || bus.out_count0 !== 8'd2) begin
      n_bad++; $display("FAIL full_pp_head2: got %h c0=%0d want 55 c0=2", bus.out_data0, bus.out_count0); end
    tick;
    bus.out_ready = 4'b0000;
    n_cmp++; if (bus.out_valid[0] !== 1'b0 || bus.out_count0 !== 8'd3) begin
      n_bad++; $display("FAIL full_pp_drain: got v=%b c0=%0d want v=0 c0=3", bus.out_valid[0], bus.out_count0); end
    $display("test_full_push_pop: 44,45,55 on port 0");
  endtask

  task automatic test_stream;
    int errs;
    errs = 0;
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    tick;
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 8'(i), 2'b11, 4'b1000);
      #1;
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; errs++; $display("FAIL stream_ready[%0d]: got %b want 1", i, bus.in_ready); end
      tick;
      n_cmp++; if (bus.out_valid[3] !== 1'b1 || bus.out_data3 !== 8'(i) || bus.out_count3 !== 8'(i)) begin
        n_bad++; errs++;
        $display("FAIL stream_word[%0d]: got v=%b d=%h c=%0d want v=1 d=%h c=%0d", i, bus.out_valid[3], bus.out_data3, bus.out_count3, 8'(i), 8'(i));
      end
    end
    bus.in_valid = 1'b0;
    tick;
    n_cmp++; if (bus.out_count3 !== 8'd44 || bus.out_valid[3] !== 1'b0) begin
      n_bad++; $display("FAIL stream_wrap: got c3=%0d v=%b want 44 v=0", bus.out_count3, bus.out_valid[3]); end
    bus.out_ready = 4'b0000;
    $display("test_stream: 300 words to port 3, %0d bad", errs);
  endtask

  task automatic test_reset_midflight;
    drive(1'b1, 8'hC1, 2'b10, 4'b0000);
    tick;
    bus.in_data = 8'hC2;
    tick;
    bus.in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++; if (bus.out_valid !== 4'b0000 || bus.in_ready !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid_valid: got valid=%b in_ready=%b want 0000 0", bus.out_valid, bus.in_ready); end
    n_cmp++; if ({bus.out_count0, bus.out_count1, bus.out_count2, bus.out_count3} !== 32'h0) begin
      n_bad++; $display("FAIL rst_mid_counts: got %0d %0d %0d %0d want all 0", bus.out_count0, bus.out_count1, bus.out_count2, bus.out_count3); end
    reset_n = 1'b1;
    drive(1'b1, 8'hD1, 2'b10, 4'b0000);
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_mid_acc1: got %b want 1", bus.in_ready); end
    tick;
    bus.in_data = 8'hD2;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_mid_acc2: got %b want 1", bus.in_ready); end
    tick;
    bus.in_data = 8'hD3;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b0 || bus.out_data2 !== 8'hD1) begin
      n_bad++; $display("FAIL rst_mid_full: got in_ready=%b d2=%h want 0 d1", bus.in_ready, bus.out_data2); end
    bus.in_valid = 1'b0;
    $display("test_reset_midflight: port 2 refilled after reset");
  endtask

  task automatic test_random;
    logic [7:0] q [4][$];
    int         cnt [4];
    int         accepted;
    int         cycles;
    int         errs;
    logic       v;
    logic [7:0] d;
    logic [1:0] s;
    logic [3:0] r;
    logic       exp_ready;
    logic [3:0] exp_valid;
    logic [7:0] got_d [4];
    logic [7:0] got_c [4];
    accepted = 0;
    cycles   = 0;
    errs     = 0;
    for (int p = 0; p < 4; p++) cnt[p] = 0;
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    tick;
    while (accepted < 10000 && cycles < 50000) begin
      v = ($urandom_range(3) != 0);
      d = 8'($urandom);
      s = 2'($urandom_range(3));
      r = 4'($urandom) | 4'($urandom);
      drive(v, d, s, r);
      #1;
      exp_ready = (q[s].size() < 2) || r[s];
      for (int p = 0; p < 4; p++) exp_valid[p] = (q[p].size() != 0);
      got_d[0] = bus.out_data0; got_d[1] = bus.out_data1; got_d[2] = bus.out_data2; got_d[3] = bus.out_data3;
      got_c[0] = bus.out_count0; got_c[1] = bus.out_count1; got_c[2] = bus.out_count2; got_c[3] = bus.out_count3;
      n_cmp++; if (bus.in_ready !== exp_ready) begin
        n_bad++; errs++; $display("FAIL rand_in_ready@%0d: got %b want %b", cycles, bus.in_ready, exp_ready); end
      n_cmp++; if (bus.out_valid !== exp_valid) begin
        n_bad++; errs++; $display("FAIL rand_out_valid@%0d: got %b want %b", cycles, bus.out_valid, exp_valid); end
      for (int p = 0; p < 4; p++) begin
        if (q[p].size() != 0) begin
          n_cmp++; if (got_d[p] !== q[p][0]) begin
            n_bad++; errs++; $display("FAIL rand_data%0d@%0d: got %h want %h", p, cycles, got_d[p], q[p][0]); end
        end
        n_cmp++; if (got_c[p] !== 8'(cnt[p])) begin
          n_bad++; errs++; $display("FAIL rand_count%0d@%0d: got %0d want %0d", p, cycles, got_c[p], 8'(cnt[p])); end
      end
      for (int p = 0; p < 4; p++) begin
        if (r[p] && q[p].size() != 0) begin
          void'(q[p].pop_front());
          cnt[p]++;
        end
      end
      if (v && exp_ready) begin
        q[s].push_back(d);
        accepted++;
      end
      tick;
      cycles++;
    end
    n_cmp++; if (accepted < 10000) begin
      n_bad++; $display("FAIL rand_budget: got %0d accepted want 10000 within 50000 cycles", accepted); end
    drive(1'b0, 8'h00, 2'b00, 4'b0000);
    $display("test_random: %0d words in %0d cycles, %0d bad", accepted, cycles, errs);
  endtask

  initial begin
    drive(1'b0, 8'h00, 2'b00, 4'b0000);
    test_reset;
    test_basic;
    test_backpressure;
    test_full_push_pop;
    test_stream;
    test_reset_midflight;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
